// File: rtl/ob_pkg.sv
// Order-book types shared by the book and the command arbiter.
// Holds the command/response structs, uid width and helpers to read and
// overwrite the port-index field carried in the uid MSBs.
package ob_pkg;

  localparam int ARB_N_PORTS_MAX = 8;
  localparam int UID_W           = 16;

  typedef logic [UID_W-1:0] uid_t;

  typedef enum logic [1:0] {OP_NEW, OP_REPLACE, OP_CANCEL, OP_NOP} op_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_TRADE, RSP_REJ, RSP_DONE} rsp_kind_t;

  typedef struct packed {
    op_t         op;
    uid_t        uid;
    uid_t        uid1;   // second order id for replace/cancel
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    rsp_kind_t   kind;
    uid_t        uid;    // trades carry the aggressor uid here
    uid_t        uid1;
    logic [15:0] qty;
  } rsp_t;

  // Port field = top pw bits of the uid.
  function automatic logic [2:0] uid_port(uid_t uid, int unsigned pw);
    return 3'(uid >> (UID_W - pw));
  endfunction

  // Replace the top pw bits of uid with port.
  function automatic uid_t uid_stamp(uid_t uid, logic [2:0] port, int unsigned pw);
    uid_t m;
    m = '1;
    m = m >> pw;
    return (uid & m) | (uid_t'(port) << (UID_W - pw));
  endfunction

endpackage

// File: rtl/ob_cmd_arb_if.sv
// Host-side bundle of the command arbiter: per-port command handshake and
// per-port response handshake with one shared response payload.
//   master : requester side (drives req_vld/req_cmd/prt_rsp_accept)
//   slave  : arbiter side (drives req_accept/prt_rsp_vld/prt_rsp)
interface ob_cmd_arb_if
  import ob_pkg::*;
#(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0] req_vld;
  cmd_t [N_PORTS-1:0] req_cmd;
  logic [N_PORTS-1:0] req_accept;
  logic [N_PORTS-1:0] prt_rsp_vld;
  rsp_t               prt_rsp;
  logic [N_PORTS-1:0] prt_rsp_accept;

  modport master (output req_vld, req_cmd, prt_rsp_accept,
                  input  req_accept, prt_rsp_vld, prt_rsp);
  modport slave  (input  req_vld, req_cmd, prt_rsp_accept,
                  output req_accept, prt_rsp_vld, prt_rsp);
endinterface

// File: rtl/ob_rr_arb.sv
// N-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   en       : grant enable (no grant when low, pointer held)
//   gnt_vld  : a grant is issued this cycle
//   gnt_idx  : granted index, gnt one-hot of the same
// The first requester at or after the pointer wins; the pointer then moves
// to one past the winner.
module ob_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt
);
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (en && !gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ob_cmd_arb.sv
// Shares one order-book command/response interface between N_PORTS hosts.
// Commands: round-robin grant, port index stamped into uid (and uid1 for
// replace/cancel) MSBs, registered toward the ob (1 cycle latency).
// Responses: one holding register, routed to the port named by the uid MSBs.
//   clk, rst      : clock, synchronous active-high reset
//   hst           : host-side bundle (ob_cmd_arb_if.slave)
//   cmd_vld_r/cmd_r, cmd_full_r : registered command to ob, ob queue full
//   rsp_vld/rsp/rsp_accept      : response from ob
// Macro OB_ARB_STATS_EN adds saturating counters on stat_cmds/stat_rsps/stat_bad.
module ob_cmd_arb
  import ob_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ob_cmd_arb_if.slave               hst,
  output logic                      cmd_vld_r,
  output cmd_t                      cmd_r,
  input  logic                      cmd_full_r,
  input  logic                      rsp_vld,
  input  rsp_t                      rsp,
  output logic                      rsp_accept
`ifdef OB_ARB_STATS_EN
  ,
  output logic [N_PORTS-1:0][31:0]  stat_cmds,
  output logic [N_PORTS-1:0][31:0]  stat_rsps,
  output logic [15:0]               stat_bad
`endif
);
  localparam int PORT_W = $clog2(N_PORTS);

  // ---- command side ----
  logic              gnt_vld;
  logic [PORT_W-1:0] gnt_idx;
  logic [N_PORTS-1:0] gnt;
  cmd_t              cmd_d;

  ob_rr_arb #(.N(N_PORTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (hst.req_vld),
    .en      (!cmd_full_r && !rst),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt     (gnt)
  );

  assign hst.req_accept = gnt;

  always_comb begin
    cmd_d     = hst.req_cmd[gnt_idx];
    cmd_d.uid = uid_stamp(cmd_d.uid, 3'(gnt_idx), PORT_W);
    if (cmd_d.op == OP_REPLACE || cmd_d.op == OP_CANCEL)
      cmd_d.uid1 = uid_stamp(cmd_d.uid1, 3'(gnt_idx), PORT_W);
  end

  // cmd_vld_r is a one-cycle pulse per grant; the ob's full threshold
  // leaves room for the one already registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_vld_r <= 1'b0;
      cmd_r     <= '0;
    end else begin
      cmd_vld_r <= gnt_vld;
      if (gnt_vld) cmd_r <= cmd_d;
    end
  end

  // ---- response side ----
  logic              hold_full_q;
  rsp_t              hold_q;
  logic [PORT_W-1:0] owner_q;
  logic              owner_acc, capture, own_ok;
  logic [2:0]        rsp_own;

  assign owner_acc  = hold_full_q && hst.prt_rsp_accept[owner_q];
  assign rsp_accept = !rst && (!hold_full_q || owner_acc);
  assign capture    = rsp_vld && rsp_accept;
  assign rsp_own    = uid_port(rsp.uid, PORT_W);
  assign own_ok     = int'(rsp_own) < N_PORTS;

  // Drain and refill may coincide, giving one response per cycle.
  // A corrupt owner is accepted from the ob but never loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      owner_q     <= '0;
    end else begin
      if (owner_acc) hold_full_q <= 1'b0;
      if (capture && own_ok) begin
        hold_full_q <= 1'b1;
        hold_q      <= rsp;
        owner_q     <= PORT_W'(rsp_own);
      end
    end
  end

  always_comb begin
    hst.prt_rsp_vld = '0;
    if (hold_full_q) hst.prt_rsp_vld[owner_q] = 1'b1;
  end
  assign hst.prt_rsp = hold_q;

`ifdef OB_ARB_STATS_EN
  logic [N_PORTS-1:0][31:0] cmds_q, rsps_q;
  logic [15:0]              bad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmds_q <= '0;
      rsps_q <= '0;
      bad_q  <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (gnt_vld && int'(gnt_idx) == p && cmds_q[p] != '1)
          cmds_q[p] <= cmds_q[p] + 32'd1;
        if (owner_acc && int'(owner_q) == p && rsps_q[p] != '1)
          rsps_q[p] <= rsps_q[p] + 32'd1;
      end
      if (capture && !own_ok && bad_q != '1) bad_q <= bad_q + 16'd1;
    end
  end

  assign stat_cmds = cmds_q;
  assign stat_rsps = rsps_q;
  assign stat_bad  = bad_q;
`endif
endmodule

// File: tb/tb_ob_cmd_arb.sv
module tb_ob_cmd_arb;
  import ob_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ob_cmd_arb_if #(.N_PORTS(N)) hif ();

  logic cmd_vld_r;
  cmd_t cmd_r;
  logic cmd_full_r;
  logic rsp_vld;
  rsp_t rsp;
  logic rsp_accept;
`ifdef OB_ARB_STATS_EN
  logic [N-1:0][31:0] stat_cmds, stat_rsps;
  logic [15:0]        stat_bad;
`endif

  ob_cmd_arb #(.N_PORTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .hst        (hif.slave),
    .cmd_vld_r  (cmd_vld_r),
    .cmd_r      (cmd_r),
    .cmd_full_r (cmd_full_r),
    .rsp_vld    (rsp_vld),
    .rsp        (rsp),
    .rsp_accept (rsp_accept)
`ifdef OB_ARB_STATS_EN
    ,
    .stat_cmds  (stat_cmds),
    .stat_rsps  (stat_rsps),
    .stat_bad   (stat_bad)
`endif
  );

  int errs   = 0;
  int checks = 0;

  typedef struct { rsp_t r; int own; } exp_rsp_t;
  cmd_t     cmdq[$];
  exp_rsp_t rspq[$];

  // expected command after the arbiter stamps port p into the uid MSBs
  function automatic cmd_t exp_cmd(cmd_t c, int p);
    cmd_t       e  = c;
    logic [1:0] pp = p[1:0];
    e.uid[15:14] = pp;
    if (c.op == OP_REPLACE || c.op == OP_CANCEL) e.uid1[15:14] = pp;
    return e;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op    = op_t'(2'($urandom_range(0, 3)));
    c.uid   = 16'($urandom);
    c.uid1  = 16'($urandom);
    c.price = 16'($urandom);
    c.qty   = 16'($urandom);
    return c;
  endfunction

  function automatic rsp_t mk_rsp(int own);
    rsp_t       r;
    logic [1:0] oo = own[1:0];
    r.kind = rsp_kind_t'(2'($urandom_range(0, 3)));
    r.uid  = 16'($urandom);
    r.uid[15:14] = oo;
    r.uid1 = 16'($urandom);
    r.qty  = 16'($urandom);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_cmds();
    for (int p = 0; p < N; p++) hif.req_cmd[p] = rand_cmd();
  endtask

  // scoreboard: pop on every issued command and every delivered response
  always @(negedge clk) begin
    if (cmd_vld_r === 1'b1) begin
      checks++;
      if (cmdq.size() == 0) begin
        errs++;
        $display("FAIL cmd_issue unexpected cmd_vld_r cmd=%h", cmd_r);
      end else begin
        cmd_t e;
        e = cmdq.pop_front();
        if (cmd_r !== e) begin
          errs++;
          $display("FAIL cmd_payload got=%h exp=%h", cmd_r, e);
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (hif.prt_rsp_vld[p] === 1'b1 && hif.prt_rsp_accept[p] === 1'b1) begin
        checks++;
        if (rspq.size() == 0) begin
          errs++;
          $display("FAIL rsp_deliver unexpected on port %0d rsp=%h", p, hif.prt_rsp);
        end else begin
          exp_rsp_t e;
          e = rspq.pop_front();
          if (hif.prt_rsp !== e.r || p != e.own) begin
            errs++;
            $display("FAIL rsp_payload port=%0d got=%h exp port=%0d rsp=%h",
                     p, hif.prt_rsp, e.own, e.r);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    cmd_full_r = 1'b0;
    hif.req_vld = '1;
    new_cmds();
    hif.prt_rsp_accept = '1;
    rsp = mk_rsp(1);
    rsp_vld = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    checks++;
    if (hif.req_accept !== 4'b0 || cmd_vld_r !== 1'b0 || cmd_r !== '0) begin
      errs++;
      $display("FAIL reset_cmd req_accept=%b cmd_vld_r=%b cmd_r=%h exp 0",
               hif.req_accept, cmd_vld_r, cmd_r);
    end
    checks++;
    if (hif.prt_rsp_vld !== 4'b0 || rsp_accept !== 1'b0) begin
      errs++;
      $display("FAIL reset_rsp prt_rsp_vld=%b rsp_accept=%b exp 0", hif.prt_rsp_vld, rsp_accept);
    end
`ifdef OB_ARB_STATS_EN
    checks++;
    if (stat_cmds !== '0 || stat_rsps !== '0 || stat_bad !== '0) begin
      errs++;
      $display("FAIL reset_stats nonzero after reset bad=%0d", stat_bad);
    end
`endif
    cyc();
    rst = 1'b0;
    hif.req_vld = '0;
    rsp_vld = 1'b0;
  endtask

  task automatic test_all_ports();
    for (int i = 0; i < 8; i++) begin
      new_cmds();
      hif.req_vld = '1;
      @(negedge clk);
      checks++;
      if (hif.req_accept !== 4'(1 << (i % 4))) begin
        errs++;
        $display("FAIL rr_all cycle %0d req_accept=%b exp=%b", i, hif.req_accept, 4'(1 << (i % 4)));
      end
      if (i > 0) begin
        checks++;
        if (cmd_vld_r !== 1'b1) begin
          errs++;
          $display("FAIL rr_all_issue cycle %0d cmd_vld_r=%b exp 1", i, cmd_vld_r);
        end
      end
      cmdq.push_back(exp_cmd(hif.req_cmd[i % 4], i % 4));
      cyc();
    end
    hif.req_vld = '0;
  endtask

  task automatic test_sparse();
    logic [3:0] msk[4];
    int         g[4];
    msk = '{4'b0010, 4'b1010, 4'b1010, 4'b1010};
    g   = '{1, 3, 1, 3};
    for (int i = 0; i < 4; i++) begin
      new_cmds();
      hif.req_vld = msk[i];
      @(negedge clk);
      checks++;
      if (hif.req_accept !== 4'(1 << g[i])) begin
        errs++;
        $display("FAIL rr_sparse step %0d req_accept=%b exp=%b", i, hif.req_accept, 4'(1 << g[i]));
      end
      cmdq.push_back(exp_cmd(hif.req_cmd[g[i]], g[i]));
      cyc();
    end
  endtask

  task automatic test_full();
    new_cmds();
    hif.req_vld = 4'b0001;
    cmd_full_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (hif.req_accept !== 4'b0) begin
        errs++;
        $display("FAIL full_accept cycle %0d req_accept=%b exp 0000", i, hif.req_accept);
      end
      checks++;
      if (cmd_vld_r !== (i == 0)) begin
        errs++;
        $display("FAIL full_issue cycle %0d cmd_vld_r=%b exp %0d", i, cmd_vld_r, i == 0);
      end
      cyc();
    end
    cmd_full_r = 1'b0;
    @(negedge clk);
    checks++;
    if (hif.req_accept !== 4'b0001) begin
      errs++;
      $display("FAIL full_release req_accept=%b exp 0001", hif.req_accept);
    end
    cmdq.push_back(exp_cmd(hif.req_cmd[0], 0));
    cyc();
    hif.req_vld = '0;
    @(negedge clk);
    checks++;
    if (cmd_vld_r !== 1'b1) begin
      errs++;
      $display("FAIL full_release_issue cmd_vld_r=%b exp 1", cmd_vld_r);
    end
    cyc();
  endtask

  task automatic test_rsp_stall();
    hif.prt_rsp_accept = '0;
    rsp = mk_rsp(2);
    rsp_vld = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_accept !== 1'b1) begin
      errs++;
      $display("FAIL stall_first rsp_accept=%b exp 1", rsp_accept);
    end
    rspq.push_back('{rsp, 2});
    cyc();
    rsp = mk_rsp(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (hif.prt_rsp_vld !== 4'b0100 || rsp_accept !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold cycle %0d prt_rsp_vld=%b rsp_accept=%b exp 0100/0",
                 i, hif.prt_rsp_vld, rsp_accept);
      end
      cyc();
    end
    hif.prt_rsp_accept = '1;
    @(negedge clk);
    checks++;
    if (hif.prt_rsp_vld !== 4'b0100 || rsp_accept !== 1'b1) begin
      errs++;
      $display("FAIL stall_release prt_rsp_vld=%b rsp_accept=%b exp 0100/1",
               hif.prt_rsp_vld, rsp_accept);
    end
    rspq.push_back('{rsp, 1});
    cyc();
    rsp_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (hif.prt_rsp_vld !== 4'b0010) begin
      errs++;
      $display("FAIL stall_second prt_rsp_vld=%b exp 0010", hif.prt_rsp_vld);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (hif.prt_rsp_vld !== 4'b0) begin
      errs++;
      $display("FAIL stall_empty prt_rsp_vld=%b exp 0000", hif.prt_rsp_vld);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int own[3];
    own = '{0, 1, 3};
    hif.prt_rsp_accept = '1;
    for (int i = 0; i < 3; i++) begin
      rsp = mk_rsp(own[i]);
      rsp_vld = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_accept !== 1'b1) begin
        errs++;
        $display("FAIL b2b_accept step %0d rsp_accept=%b exp 1", i, rsp_accept);
      end
      if (i > 0) begin
        checks++;
        if (hif.prt_rsp_vld !== 4'(1 << own[i-1])) begin
          errs++;
          $display("FAIL b2b_vld step %0d prt_rsp_vld=%b exp=%b", i, hif.prt_rsp_vld, 4'(1 << own[i-1]));
        end
      end
      rspq.push_back('{rsp, own[i]});
      cyc();
    end
    rsp_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (hif.prt_rsp_vld !== 4'b1000) begin
      errs++;
      $display("FAIL b2b_last prt_rsp_vld=%b exp 1000", hif.prt_rsp_vld);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (hif.prt_rsp_vld !== 4'b0) begin
      errs++;
      $display("FAIL b2b_empty prt_rsp_vld=%b exp 0000", hif.prt_rsp_vld);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    // rr pointer is 1 here (last grant was port 0)
    hif.prt_rsp_accept = '0;
    rsp = mk_rsp(3);
    rsp_vld = 1'b1;
    new_cmds();
    hif.req_vld = 4'b0010;
    @(negedge clk);
    checks++;
    if (hif.req_accept !== 4'b0010 || rsp_accept !== 1'b1) begin
      errs++;
      $display("FAIL mid_setup req_accept=%b rsp_accept=%b exp 0010/1", hif.req_accept, rsp_accept);
    end
    cmdq.push_back(exp_cmd(hif.req_cmd[1], 1));
    rspq.push_back('{rsp, 3});
    cyc();
    rsp_vld = 1'b0;
    hif.req_vld = '1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_vld_r !== 1'b1 || hif.prt_rsp_vld !== 4'b1000) begin
      errs++;
      $display("FAIL mid_inflight cmd_vld_r=%b prt_rsp_vld=%b exp 1/1000", cmd_vld_r, hif.prt_rsp_vld);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (cmd_vld_r !== 1'b0 || cmd_r !== '0 || hif.req_accept !== 4'b0 ||
        hif.prt_rsp_vld !== 4'b0 || rsp_accept !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset cmd_vld_r=%b cmd_r=%h req_accept=%b prt_rsp_vld=%b rsp_accept=%b exp all 0",
               cmd_vld_r, cmd_r, hif.req_accept, hif.prt_rsp_vld, rsp_accept);
    end
`ifdef OB_ARB_STATS_EN
    checks++;
    if (stat_cmds !== '0 || stat_rsps !== '0 || stat_bad !== '0) begin
      errs++;
      $display("FAIL mid_reset_stats nonzero after reset bad=%0d", stat_bad);
    end
`endif
    rspq.delete();
    cyc();
    rst = 1'b0;
    hif.prt_rsp_accept = '1;
    @(negedge clk);
    checks++;
    if (hif.req_accept !== 4'b0001 || rsp_accept !== 1'b1 || hif.prt_rsp_vld !== 4'b0) begin
      errs++;
      $display("FAIL mid_after req_accept=%b rsp_accept=%b prt_rsp_vld=%b exp 0001/1/0000",
               hif.req_accept, rsp_accept, hif.prt_rsp_vld);
    end
    cmdq.push_back(exp_cmd(hif.req_cmd[0], 0));
    cyc();
    hif.req_vld = '0;
    repeat (2) cyc();
  endtask

  initial begin
    rst = 1'b1;
    cmd_full_r = 1'b0;
    rsp_vld = 1'b0;
    rsp = '0;
    hif.req_vld = '0;
    hif.req_cmd = '0;
    hif.prt_rsp_accept = '0;
    test_reset();
    test_all_ports();
    test_sparse();
    test_full();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (cmdq.size() != 0 || rspq.size() != 0) begin
      errs++;
      $display("FAIL drain cmds_left=%0d rsps_left=%0d exp 0/0", cmdq.size(), rspq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ob_cmd_arb.md
Name: ob_cmd_arb

Overview:
- Shares the single order-book command/response interface between N independent host requester ports.
- Round-robin arbitration on commands; stamps the port index into the uid MSBs; routes each ob response back to the owning port by those MSBs.
- Sits directly in front of the ob instance; drives its cmd_vld_r/cmd_r and consumes its rsp_vld/rsp/rsp_accept.

Parameters:
- N_PORTS, 4, number of requester ports (2..8).
- PORT_W, $clog2(N_PORTS), uid MSB field carrying the port index (derived; not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  N_PORTS  per-port command valid
- req_cmd  in  N_PORTS x $bits(ob_pkg::cmd_t)  per-port command
- req_accept  out  N_PORTS  per-port command accepted this cycle
- prt_rsp_vld  out  N_PORTS  per-port response valid
- prt_rsp  out  $bits(ob_pkg::rsp_t)  response payload, shared by all ports, qualified by prt_rsp_vld
- prt_rsp_accept  in  N_PORTS  per-port response accept
- cmd_vld_r  out  1  registered command valid to ob
- cmd_r  out  $bits(ob_pkg::cmd_t)  registered command to ob
- cmd_full_r  in  1  ob command queue full (registered in ob)
- rsp_vld  in  1  ob response valid
- rsp  in  $bits(ob_pkg::rsp_t)  ob response
- rsp_accept  out  1  response accepted from ob

Behaviour:
- Reset values: req_accept=0, cmd_vld_r=0, cmd_r=0, prt_rsp_vld=0, rsp_accept=0, rr pointer=0, response holding register empty.
- Arbitration:
  - Grant only when cmd_full_r==0.
  - Grant goes to the first requesting port at or after rr_ptr, with wrap.
  - req_accept[g]=1 in the grant cycle (combinational from req_vld, rr_ptr, cmd_full_r).
  - rr_ptr <= (g+1) mod N_PORTS on grant; unchanged when there is no grant.
- Command issue:
  - Granted command is registered: cmd_vld_r=1 next cycle for exactly one cycle per grant.
  - cmd_r = req_cmd[g] with uid[UID_W-1 -: PORT_W] overwritten by g.
  - uid1 is stamped the same way for opcodes carrying a second uid (replace/cancel).
  - Latency: request to cmd_vld_r is 1 cycle. Throughput: 1 command/cycle while cmd_full_r==0.
- cmd_full_r asserted: no grant and no req_accept. An already-registered cmd_vld_r still issues; ob's full threshold accounts for one in flight.
- Response path:
  - rsp_accept = holding register empty, or its owner accepts this cycle.
  - On rsp_vld && rsp_accept, rsp is captured into the holding register; owner = rsp.uid[UID_W-1 -: PORT_W].
  - prt_rsp_vld[owner]=1 while the holding register is full; prt_rsp = held rsp with uid port bits unmodified.
  - Register empties on prt_rsp_accept[owner]; the same cycle may load the next response (full rate).
  - Trade responses route by rsp.uid (aggressor uid).
  - Owner index >= N_PORTS (corrupt uid): response is dropped, and the error counter increments if stats are enabled.
- Simultaneous events: grant and response capture are independent and may occur in the same cycle.
- Reset mid-operation: all in-flight state is discarded; the ob is reset by the same rst.

Optional Feature:
- OB_ARB_STATS_EN defined:
  - Per-port 32-bit counters cmds_issued[p] and rsps_delivered[p], plus a 16-bit bad_owner counter. All saturating, cleared by rst.
  - Exposed on outputs stat_cmds, stat_rsps (N_PORTS x 32) and stat_bad (16).
- OB_ARB_STATS_EN undefined: counters and stat ports absent; behaviour otherwise identical.

Decomposition:
- ob_pkg:
  - ARB_N_PORTS_MAX=8.
  - Function ob_pkg::uid_port(uid) returning the port field.
  - Function ob_pkg::uid_stamp(uid, port).
- One sub-module, ob_rr_arb: N-way round-robin grant with rr_ptr state, reusable elsewhere.
- Response holding register stays inline.

Test Plan:
- All 4 ports assert req_vld continuously, cmd_full_r=0 -> grants 0,1,2,3,0,1… one per cycle; cmd_r.uid MSBs = grant index; cmd_vld_r each cycle from cycle 1.
- Ports 1 and 3 requesting, rr_ptr=2 -> grant 3, then 1, then 3; ports 0 and 2 never accepted.
- cmd_full_r=1 for 5 cycles with port 0 requesting -> req_accept[0]=0 for those 5 cycles, no new cmd_vld_r; grant in the first cycle after cmd_full_r=0.
- ob response with uid port field=2, prt_rsp_accept[2]=0 for 3 cycles -> prt_rsp_vld[2] high 3+ cycles, rsp_accept=0 for a second rsp_vld; both delivered in order once accepted.
- Back-to-back responses owned by ports 0 then 1, all accepts high -> one delivery per cycle, rsp_accept held at 1.
- rst asserted while the holding register is full and cmd_vld_r=1 -> next cycle all outputs 0, rr_ptr=0; with OB_ARB_STATS_EN, counters read 0.
